// File: rtl/seq_player.sv
// Plays a stored colour sequence from a pattern ROM onto the LEDs.
// Each step is lit for ON_CYCLES clocks and followed by an OFF_CYCLES blank gap.
module seq_player #(
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned DATA_W     = 4,
    parameter int unsigned ON_CYCLES  = 25000000,
    parameter int unsigned OFF_CYCLES = 12500000,
    parameter int unsigned CNT_W      = 25
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   level,
    input  logic              abort,
    input  logic [DATA_W-1:0] rom_data,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] led,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHOW,
        GAP,
        DONE
    } state_t;

    localparam logic [ADDR_W:0]   MAX_LEN  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   ONE_LEN  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ONE_ADDR = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  ONE_CNT  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  ON_LAST  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0]  OFF_LAST = CNT_W'(OFF_CYCLES - 1);

    state_t              state, state_nx;
    logic [CNT_W-1:0]    timer;
    logic [ADDR_W:0]     len, len_nx;
    logic [ADDR_W-1:0]   addr_nx;
    logic [DATA_W-1:0]   led_nx;
    logic                busy_nx, done_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        len_nx   = len;
        addr_nx  = address;
        led_nx   = '0;
        busy_nx  = 1'b0;
        done_nx  = 1'b0;

        case (state)
            IDLE: begin
                if (start && !abort && (level != '0)) begin
                    len_nx   = (level > MAX_LEN) ? MAX_LEN : level;
                    addr_nx  = '0;
                    state_nx = FETCH;
                end
            end
            FETCH: state_nx = SHOW;
            SHOW: begin
                if (timer == ON_LAST) state_nx = GAP;
            end
            GAP: begin
                if (timer == OFF_LAST) begin
                    // Last step is detected before incrementing, so a full-depth
                    // sequence ends on the top address without wrapping.
                    if (({1'b0, address} + ONE_LEN) == len) begin
                        state_nx = DONE;
                    end else begin
                        addr_nx  = address + ONE_ADDR;
                        state_nx = FETCH;
                    end
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        if (abort && (state == FETCH || state == SHOW || state == GAP)) begin
            state_nx = IDLE;
        end

        // Outputs are registered, so they are derived from the state being entered.
        case (state_nx)
            IDLE:  addr_nx = '0;
            FETCH: busy_nx = 1'b1;
            SHOW: begin
                busy_nx = 1'b1;
                led_nx  = (state == FETCH) ? rom_data : led;
            end
            GAP:   busy_nx = 1'b1;
            DONE:  done_nx = 1'b1;
            default: addr_nx = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len     <= '0;
            address <= '0;
            led     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            timer   <= '0;
        end else begin
            len     <= len_nx;
            address <= addr_nx;
            led     <= led_nx;
            busy    <= busy_nx;
            done    <= done_nx;
            timer   <= (state_nx != state) ? '0 : timer + ONE_CNT;
        end
    end

endmodule

// File: tb/tb_seq_player.sv
// Directed bench for seq_player with ON_CYCLES=3, OFF_CYCLES=2 and a
// walking-one ROM model; expected outputs are computed per cycle from the run length.
module tb_seq_player;

    logic       clk;
    logic       rst;
    logic       start;
    logic [4:0] level;
    logic       abort;
    logic [3:0] rom_data;
    logic [3:0] address;
    logic [3:0] led;
    logic       busy;
    logic       done;
    logic       rom_force;

    int n_checks = 0;
    int n_fail   = 0;

    seq_player #(
        .ADDR_W    (4),
        .DATA_W    (4),
        .ON_CYCLES (3),
        .OFF_CYCLES(2),
        .CNT_W     (25)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .level   (level),
        .abort   (abort),
        .rom_data(rom_data),
        .address (address),
        .led     (led),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] walk_one;
    assign walk_one = 4'b0001 << address[1:0];
    assign rom_data = rom_force ? 4'b1111 : walk_one;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input int e_addr, input int e_led,
                                 input int e_busy, input int e_done);
        check({tag, " address"}, 32'(address), 32'(e_addr));
        check({tag, " led"},     32'(led),     32'(e_led));
        check({tag, " busy"},    32'(busy),    32'(e_busy));
        check({tag, " done"},    32'(done),    32'(e_done));
    endtask

    // Starts a run with start sampled at E0, then checks cycles 1..ncyc.
    // pulse_k / abort_k drive start / abort during that cycle (0 = never);
    // the ROM is forced to all-ones in cycles frc_lo .. frc_hi-1.
    task automatic play(input string name, input logic [4:0] lvl, input int len, input int ncyc,
                        input int pulse_k, input int abort_k, input int frc_lo, input int frc_hi);
        int t;
        int s, ph, e_addr, e_led, e_busy, e_done;
        t     = 6 * len;
        level = lvl;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            if (k > 1) begin
                @(posedge clk);
                #1;
            end
            e_addr = 0; e_led = 0; e_busy = 0; e_done = 0;
            if (abort_k > 0 && k > abort_k) begin
                e_addr = 0;
            end else if (k <= t) begin
                s      = (k - 1) / 6;
                ph     = (k - 1) % 6;
                e_addr = s;
                e_busy = 1;
                if (ph >= 1 && ph <= 3) e_led = 1 << (s % 4);
            end else if (len > 0 && k == t + 1) begin
                e_done = 1;
                e_addr = len - 1;
            end
            check_outputs($sformatf("%s c%0d", name, k), e_addr, e_led, e_busy, e_done);
            start     = (k == pulse_k);
            abort     = (k == abort_k);
            rom_force = (k >= frc_lo && k < frc_hi);
        end
        start     = 1'b0;
        abort     = 1'b0;
        rom_force = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        level     = '0;
        rom_force = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", 0, 0, 0, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_outputs("idle", 0, 0, 0, 0);

        play("lvl1", 5'd1, 1, 9, 0, 0, 0, 0);
        play("lvl16", 5'd16, 16, 100, 0, 0, 0, 0);
        play("lvl0", 5'd0, 0, 10, 0, 0, 0, 0);
        play("lvl20", 5'd20, 16, 100, 0, 0, 0, 0);
        play("restart", 5'd3, 3, 22, 5, 0, 0, 0);
        play("abort", 5'd3, 3, 30, 0, 6, 0, 0);
        play("romforce", 5'd1, 1, 9, 0, 0, 2, 5);

        // start together with abort in IDLE must not launch playback
        level = 5'd2;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) begin
                @(posedge clk);
                #1;
            end
            check_outputs($sformatf("startabort c%0d", k), 0, 0, 0, 0);
        end

        // asynchronous reset in the middle of SHOW
        level = 5'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check_outputs("pre-rst show", 0, 1, 1, 0);
        #2;
        rst = 1'b1;
        #1;
        check_outputs("async rst", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        play("post-rst", 5'd1, 1, 9, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
